// File: rtl/bids_nch.sv
// N-bidder timed-round bid controller: configured while unlocked, bids run in rounds.
// Optional retract support is built only when BIDS_RETRACT_EN is defined.
module bids_nch #(
    parameter int NUM_BIDDERS = 3,
    parameter int AMT_W       = 16,
    parameter int BAL_W       = 32,
    parameter int TIMER_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_BIDDERS-1:0]       bid,
    input  logic [NUM_BIDDERS-1:0]       retract,
    input  logic [NUM_BIDDERS*AMT_W-1:0] bidAmt,
    input  logic                         c_start,
    input  logic [3:0]                   c_op,
    input  logic [31:0]                  c_data,
    output logic [NUM_BIDDERS-1:0]       ack,
    output logic [NUM_BIDDERS-1:0]       win,
    output logic [2*NUM_BIDDERS-1:0]     bidder_err,
    output logic [NUM_BIDDERS*BAL_W-1:0] balance,
    output logic [AMT_W-1:0]             maxBid,
    output logic                         ready,
    output logic                         roundOver,
    output logic [2:0]                   err
);
    localparam int SEL_W = $clog2(NUM_BIDDERS);

    typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_ROUND} state_t;

    state_t                             state;
    logic [31:0]                        key;
    logic [SEL_W-1:0]                   sel;
    logic [NUM_BIDDERS-1:0]             mask;
    logic [TIMER_W-1:0]                 timer_reload;
    logic [TIMER_W-1:0]                 timer;
    logic [BAL_W-1:0]                   bid_cost;
    logic [NUM_BIDDERS-1:0][BAL_W-1:0]  bal_q, bal_n;
    logic                               lead_vld, lead_vld_n;
    logic [SEL_W-1:0]                   lead, lead_n;
    logic [AMT_W-1:0]                   max_q, max_n;
    logic [NUM_BIDDERS-1:0]             ack_n, win_n;
    logic [NUM_BIDDERS-1:0][1:0]        berr_n;
    logic                               round_end;

    assign balance   = bal_q;
    assign maxBid    = max_q;
    assign round_end = (state == ST_ROUND) && (timer == TIMER_W'(1));

`ifndef BIDS_RETRACT_EN
    logic unused_retract;
    assign unused_retract = ^retract;
`endif

    // Bidder side: retracts first, then bids in index order against a running max.
    always_comb begin
        logic [AMT_W-1:0] amt;
        logic [BAL_W:0]   need;
        amt        = '0;
        need       = '0;
        bal_n      = bal_q;
        lead_vld_n = lead_vld;
        lead_n     = lead;
        max_n      = max_q;
        ack_n      = '0;
        win_n      = '0;
        berr_n     = '0;
        if (state == ST_ROUND) begin
`ifdef BIDS_RETRACT_EN
            for (int i = 0; i < NUM_BIDDERS; i++) begin
                if (retract[i] && !bid[i]) begin
                    if (!mask[i]) begin
                        berr_n[i] = 2'b01;
                    end else if (lead_vld && lead == SEL_W'(i)) begin
                        lead_vld_n = 1'b0;
                        max_n      = '0;
                        ack_n[i]   = 1'b1;
                    end else begin
                        berr_n[i] = 2'b11;
                    end
                end
            end
`endif
            for (int i = 0; i < NUM_BIDDERS; i++) begin
                if (bid[i]) begin
                    amt  = bidAmt[i*AMT_W +: AMT_W];
                    need = (BAL_W+1)'(amt) + (BAL_W+1)'(bid_cost);
                    if (!mask[i]) begin
                        berr_n[i] = 2'b01;
                    end else if ({1'b0, bal_q[i]} < need) begin
                        berr_n[i] = 2'b10;
                    end else if (amt <= max_n) begin
                        berr_n[i] = 2'b11;
                    end else begin
                        bal_n[i]   = bal_q[i] - bid_cost;
                        lead_vld_n = 1'b1;
                        lead_n     = SEL_W'(i);
                        max_n      = amt;
                        ack_n[i]   = 1'b1;
                    end
                end
            end
            // Bids taken on the final edge still count toward the winner.
            if (round_end && lead_vld_n) begin
                win_n[lead_n] = 1'b1;
                bal_n[lead_n] = bal_n[lead_n] - BAL_W'(max_n);
            end
        end else begin
            for (int i = 0; i < NUM_BIDDERS; i++) begin
`ifdef BIDS_RETRACT_EN
                if (bid[i] || retract[i]) berr_n[i] = 2'b01;
`else
                if (bid[i]) berr_n[i] = 2'b01;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_UNLOCKED;
            key          <= '0;
            sel          <= '0;
            mask         <= '1;
            timer_reload <= TIMER_W'(15);
            timer        <= '0;
            bid_cost     <= BAL_W'(1);
            bal_q        <= '0;
            lead_vld     <= 1'b0;
            lead         <= '0;
            max_q        <= '0;
            ack          <= '0;
            win          <= '0;
            bidder_err   <= '0;
            ready        <= 1'b1;
            roundOver    <= 1'b0;
            err          <= '0;
        end else begin
            ack        <= ack_n;
            win        <= win_n;
            bidder_err <= berr_n;
            bal_q      <= bal_n;
            lead_vld   <= lead_vld_n;
            lead       <= lead_n;
            max_q      <= max_n;
            roundOver  <= 1'b0;
            err        <= '0;
            if (state == ST_ROUND) begin
                timer <= timer - TIMER_W'(1);
                if (round_end) begin
                    state     <= ST_LOCKED;
                    ready     <= 1'b1;
                    roundOver <= 1'b1;
                end
            end else if (state == ST_LOCKED && c_start && timer_reload != '0) begin
                // A valid start wins over any opcode presented in the same cycle.
                state    <= ST_ROUND;
                ready    <= 1'b0;
                timer    <= timer_reload;
                max_q    <= '0;
                lead_vld <= 1'b0;
            end else begin
                case (c_op)
                    4'd0: begin
                        if (c_start) err <= (state == ST_UNLOCKED) ? 3'b011 : 3'b110;
                    end
                    4'd1: begin
                        if (c_data == key) state <= ST_UNLOCKED;
                        else               err   <= 3'b001;
                    end
                    4'd2: begin
                        if (state == ST_LOCKED) begin
                            err <= 3'b010;
                        end else begin
                            key   <= c_data;
                            state <= ST_LOCKED;
                        end
                    end
                    4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                        if (state == ST_LOCKED) begin
                            err <= 3'b010;
                        end else begin
                            case (c_op)
                                4'd3: begin
                                    if (c_data >= 32'(NUM_BIDDERS)) err <= 3'b100;
                                    else                            sel <= c_data[SEL_W-1:0];
                                end
                                4'd4:    bal_q[sel]   <= c_data[BAL_W-1:0];
                                4'd5:    mask         <= c_data[NUM_BIDDERS-1:0];
                                4'd6:    timer_reload <= c_data[TIMER_W-1:0];
                                default: bid_cost     <= c_data[BAL_W-1:0];
                            endcase
                        end
                    end
                    default: err <= 3'b100;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bids_nch.sv
// Self-checking bench for bids_nch: directed scenarios plus random traffic vs. a behavioural model.
module tb_bids_nch;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  bid, retract;
    logic [47:0] bidAmt;
    logic        c_start;
    logic [3:0]  c_op;
    logic [31:0] c_data;
    logic [2:0]  ack, win;
    logic [5:0]  bidder_err;
    logic [95:0] balance;
    logic [15:0] maxBid;
    logic        ready, roundOver;
    logic [2:0]  err;

    bids_nch #(.NUM_BIDDERS(3), .AMT_W(16), .BAL_W(32), .TIMER_W(16)) dut (
        .clk(clk), .reset(reset), .bid(bid), .retract(retract), .bidAmt(bidAmt),
        .c_start(c_start), .c_op(c_op), .c_data(c_data), .ack(ack), .win(win),
        .bidder_err(bidder_err), .balance(balance), .maxBid(maxBid), .ready(ready),
        .roundOver(roundOver), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: 0 unlocked, 1 locked, 2 in round; leader -1 means none.
    int          m_state, m_sel, m_reload, m_lead, m_max, m_timer;
    logic [31:0] m_key;
    logic [2:0]  m_mask;
    longint      m_cost;
    longint      m_bal[3];
    logic [2:0]  e_ack, e_win, e_err;
    logic [5:0]  e_berr;
    logic [95:0] e_bal;
    logic        e_ro;

    task automatic model_step();
        int amt;
        e_ack = 0; e_win = 0; e_berr = 0; e_ro = 0; e_err = 0;
        if (reset) begin
            m_state = 0; m_key = 0; m_sel = 0; m_mask = 3'b111; m_reload = 15; m_cost = 1;
            for (int i = 0; i < 3; i++) m_bal[i] = 0;
            m_lead = -1; m_max = 0; m_timer = 0;
        end else if (m_state == 2) begin
`ifdef BIDS_RETRACT_EN
            for (int i = 0; i < 3; i++)
                if (retract[i] && !bid[i]) begin
                    if (!m_mask[i])       e_berr[2*i +: 2] = 2'b01;
                    else if (m_lead == i) begin m_lead = -1; m_max = 0; e_ack[i] = 1; end
                    else                  e_berr[2*i +: 2] = 2'b11;
                end
`endif
            for (int i = 0; i < 3; i++)
                if (bid[i]) begin
                    amt = int'(bidAmt[16*i +: 16]);
                    if (!m_mask[i])                          e_berr[2*i +: 2] = 2'b01;
                    else if (m_bal[i] < longint'(amt) + m_cost) e_berr[2*i +: 2] = 2'b10;
                    else if (amt <= m_max)                   e_berr[2*i +: 2] = 2'b11;
                    else begin
                        m_bal[i] -= m_cost; m_lead = i; m_max = amt; e_ack[i] = 1;
                    end
                end
            m_timer--;
            if (m_timer == 0) begin
                e_ro = 1; m_state = 1;
                if (m_lead >= 0) begin e_win[m_lead] = 1; m_bal[m_lead] -= m_max; end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
`ifdef BIDS_RETRACT_EN
                if (bid[i] || retract[i]) e_berr[2*i +: 2] = 2'b01;
`else
                if (bid[i]) e_berr[2*i +: 2] = 2'b01;
`endif
            end
            if (m_state == 1 && c_start && m_reload > 0) begin
                m_state = 2; m_timer = m_reload; m_max = 0; m_lead = -1;
            end else if (c_op == 0) begin
                if (c_start) e_err = (m_state == 0) ? 3'b011 : 3'b110;
            end else if (c_op >= 8) e_err = 3'b100;
            else if (c_op == 1) begin
                if (c_data == m_key) m_state = 0; else e_err = 3'b001;
            end else if (c_op == 2) begin
                if (m_state == 1) e_err = 3'b010; else begin m_key = c_data; m_state = 1; end
            end else if (m_state == 1) e_err = 3'b010;
            else case (c_op)
                4'd3: if (c_data >= 3) e_err = 3'b100; else m_sel = int'(c_data);
                4'd4: m_bal[m_sel] = longint'(c_data);
                4'd5: m_mask = c_data[2:0];
                4'd6: m_reload = int'(c_data[15:0]);
                default: m_cost = longint'(c_data);
            endcase
        end
        for (int i = 0; i < 3; i++) e_bal[32*i +: 32] = m_bal[i][31:0];
    endtask

    task automatic step();
        model_step();
        @(posedge clk); #1;
        chk("ack", ack, e_ack);
        chk("win", win, e_win);
        chk("bidder_err", bidder_err, e_berr);
        chk("balance", balance, e_bal);
        chk("maxBid", maxBid, m_max[15:0]);
        chk("ready", ready, m_state != 2);
        chk("roundOver", roundOver, e_ro);
        chk("err", err, e_err);
    endtask

    task automatic op(input logic [3:0] o, input logic [31:0] d);
        c_op = o; c_data = d; step(); c_op = 0; c_data = 0;
    endtask

    task automatic start_round();
        c_start = 1; step(); c_start = 0;
    endtask

    task automatic run_to_end(output logic got_ro, output logic [2:0] got_win);
        got_ro = 0; got_win = 0;
        for (int n = 0; n < 40 && !got_ro; n++) begin
            step();
            if (roundOver === 1'b1) begin got_ro = 1; got_win = win; end
        end
    endtask

    logic       ro;
    logic [2:0] w;
    int         r;

    initial begin
        reset = 1; bid = 0; retract = 0; bidAmt = 0; c_start = 0; c_op = 0; c_data = 0;
        step(); step();
        chk("rst_ready", ready, 1'b1);
        chk("rst_maxBid", maxBid, 16'd0);
        chk("rst_balance", balance, 96'd0);
        reset = 0;

        // Plan 1/2: equal bids same cycle, then X wins at 10 after 4 edges.
        for (int i = 0; i < 3; i++) begin op(3, i); op(4, 100); end
        op(6, 4); op(2, 32'h5A);
        start_round();
        chk("start_ready", ready, 1'b0);
        bid = 3'b011; bidAmt[15:0] = 10; bidAmt[31:16] = 10; step(); bid = 0;
        chk("p1_ack", ack, 3'b001);
        chk("p1_berr_y", bidder_err[3:2], 2'b11);
        chk("p1_maxBid", maxBid, 16'd10);
        chk("p1_bal_x", balance[31:0], 32'd99);
        step(); step(); step();
        chk("p2_roundOver", roundOver, 1'b1);
        chk("p2_win", win, 3'b001);
        chk("p2_bal_x", balance[31:0], 32'd89);
        chk("p2_ready", ready, 1'b1);

        // Plan 3: insufficient funds boundary.
        op(1, 32'h5A); op(3, 0); op(4, 5); op(2, 32'h5A);
        start_round();
        bid = 3'b001; bidAmt[15:0] = 5; step();
        chk("funds_berr", bidder_err[1:0], 2'b10);
        bidAmt[15:0] = 4; step(); bid = 0;
        chk("funds_ack", ack, 3'b001);
        run_to_end(ro, w);
        chk("funds_ro", ro, 1'b1);
        chk("funds_win", w, 3'b001);
        chk("funds_bal", balance[31:0], 32'd0);

        // Plan 4: wrong key, then config op while locked.
        op(1, 32'h11);
        chk("badkey_err", err, 3'b001);
        op(4, 7);
        chk("locked_err", err, 3'b010);

        // Plan 5: eligibility.
        op(1, 32'h5A); op(5, 5); op(2, 32'h5A);
        bid = 3'b010; bidAmt[31:16] = 3; step(); bid = 0;
        chk("idle_berr", bidder_err[3:2], 2'b01);
        start_round();
        bid = 3'b010; step(); bid = 0;
        chk("mask_berr", bidder_err[3:2], 2'b01);
        run_to_end(ro, w);
        chk("mask_ro", ro, 1'b1);
        chk("mask_win", w, 3'b000);

        // Plan 6: leader retract.
        op(1, 32'h5A); op(5, 7); op(3, 0); op(4, 50); op(2, 32'h5A);
        start_round();
        bid = 3'b001; bidAmt[15:0] = 7; step(); bid = 0;
        chk("rt_ack_bid", ack, 3'b001);
        retract = 3'b001; step(); retract = 0;
`ifdef BIDS_RETRACT_EN
        chk("rt_ack", ack, 3'b001);
        chk("rt_maxBid", maxBid, 16'd0);
        run_to_end(ro, w);
        chk("rt_win", w, 3'b000);
`else
        chk("rt_ack", ack, 3'b000);
        chk("rt_berr", bidder_err, 6'd0);
        chk("rt_maxBid", maxBid, 16'd7);
        run_to_end(ro, w);
        chk("rt_win", w, 3'b001);
`endif
        chk("rt_ro", ro, 1'b1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < 3; i++) begin
                bid[i]     = ($urandom_range(0, 9) < 4);
                retract[i] = ($urandom_range(0, 9) < 1);
                bidAmt[16*i +: 16] = 16'($urandom_range(0, 40));
            end
            c_start = ($urandom_range(0, 3) == 0);
            c_op = 0; c_data = 0;
            if (!c_start && $urandom_range(0, 2) == 0) begin
                c_op = 4'($urandom_range(1, 9));
                r = $urandom_range(0, 1);
                case (c_op)
                    4'd1: c_data = r ? m_key : 32'($urandom_range(0, 3));
                    4'd2: c_data = 32'($urandom_range(0, 3));
                    4'd3: c_data = 32'($urandom_range(0, 3));
                    4'd4: c_data = 32'($urandom_range(0, 150));
                    4'd5: c_data = 32'($urandom_range(0, 7));
                    4'd6: c_data = 32'($urandom_range(0, 6));
                    4'd7: c_data = 32'($urandom_range(0, 3));
                    default: c_data = $urandom;
                endcase
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
